// File: rtl/atomic_unit.sv
// RV32A atomic unit: LR.W / SC.W / AMO*.W sequencer in MEM.
// Holds the LR reservation and drives the data-memory port.
module atomic_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int GRANULE_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_lr,
  input  logic                  is_sc,
  input  logic                  is_amo,
  input  logic [4:0]            amo_funct5,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           rs2_data,
  input  logic                  flush,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           result,
  output logic                  misaligned,
  output logic                  illegal
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  localparam int TW = ADDR_WIDTH - GRANULE_BITS;

  logic [1:0]            state;
  logic                  op_lr;
  logic                  op_sc;
  logic [4:0]            f5_q;
  logic [31:0]           rs2_q;
  logic [31:0]           old_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  res_valid;
  logic [TW-1:0]         res_tag;

  logic                  f5_ok;
  logic [31:0]           amo_new;
  logic                  sel_lr;
  logic                  sel_sc;
  logic                  sel_amo;
  logic                  mis_in;
  logic                  ill_in;
  logic                  snoop_res;
  logic                  snoop_lr;
  logic                  res_hit;
  logic                  sc_start;
  logic                  lr_done;

  assign sel_lr  = is_lr;
  assign sel_sc  = !is_lr && is_sc;
  assign sel_amo = !is_lr && !is_sc && is_amo;
  assign mis_in  = addr[1:0] != 2'b00;
  assign ill_in  = sel_amo && !f5_ok;

  assign snoop_res = snoop_valid &&
    (snoop_addr[ADDR_WIDTH-1:GRANULE_BITS] == res_tag);
  assign snoop_lr  = snoop_valid &&
    (snoop_addr[ADDR_WIDTH-1:GRANULE_BITS] ==
     addr_q[ADDR_WIDTH-1:GRANULE_BITS]);
  assign res_hit = res_valid && !flush && !snoop_res &&
    (addr[ADDR_WIDTH-1:GRANULE_BITS] == res_tag);

  assign sc_start = (state == IDLE) && start && sel_sc;
  assign lr_done  = (state == READ) && mem_ready && op_lr;

  assign mem_req  = (state == READ) || (state == WRITE);
  assign mem_we   = (state == WRITE);
  assign busy     = mem_req;
  assign done     = (state == DONE);
  assign mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Decode which AMO funct5 encodings are supported
  always_comb begin
    f5_ok = 1'b0;
    case (amo_funct5)
      F_ADD, F_SWAP, F_XOR, F_AND, F_OR,
      F_MIN, F_MAX, F_MINU, F_MAXU: f5_ok = 1'b1;
      default: f5_ok = 1'b0;
    endcase
  end

  // AMO new value from the read data and latched operand
  always_comb begin
    amo_new = rs2_q;
    case (f5_q)
      F_ADD:  amo_new = mem_rdata + rs2_q;
      F_XOR:  amo_new = mem_rdata ^ rs2_q;
      F_AND:  amo_new = mem_rdata & rs2_q;
      F_OR:   amo_new = mem_rdata | rs2_q;
      F_MIN:  amo_new = ($signed(mem_rdata) < $signed(rs2_q))
                        ? mem_rdata : rs2_q;
      F_MAX:  amo_new = ($signed(mem_rdata) > $signed(rs2_q))
                        ? mem_rdata : rs2_q;
      F_MINU: amo_new = (mem_rdata < rs2_q) ? mem_rdata : rs2_q;
      F_MAXU: amo_new = (mem_rdata > rs2_q) ? mem_rdata : rs2_q;
      default: amo_new = rs2_q;
    endcase
  end

  // Reservation: clears beat a same-cycle LR completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
    end else if (lr_done) begin
      res_valid <= !(flush || snoop_lr);
      res_tag   <= addr_q[ADDR_WIDTH-1:GRANULE_BITS];
    end else if (flush || snoop_res || sc_start) begin
      res_valid <= 1'b0;
    end
  end

  // Op sequencer: IDLE -> READ -> WRITE -> DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_lr      <= 1'b0;
      op_sc      <= 1'b0;
      f5_q       <= '0;
      rs2_q      <= '0;
      old_q      <= '0;
      addr_q     <= '0;
      mem_wdata  <= '0;
      result     <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (is_lr || is_sc || is_amo)) begin
            addr_q     <= addr;
            rs2_q      <= rs2_data;
            f5_q       <= amo_funct5;
            op_lr      <= sel_lr;
            op_sc      <= sel_sc;
            misaligned <= mis_in;
            illegal    <= ill_in;
            if (mis_in || ill_in) begin
              result <= '0;
              state  <= DONE;
            end else if (sel_sc) begin
              if (res_hit) begin
                mem_wdata <= rs2_data;
                state     <= WRITE;
              end else begin
                result <= 32'd1;
                state  <= DONE;
              end
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (mem_ready) begin
            old_q <= mem_rdata;
            if (op_lr) begin
              result <= mem_rdata;
              state  <= DONE;
            end else begin
              mem_wdata <= amo_new;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            result <= op_sc ? 32'd0 : old_q;
            state  <= DONE;
          end
        end
        DONE: begin
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atomic_unit.sv
// Directed bench for atomic_unit.
// Memory responder with stall control, latency/result checks.
module tb_atomic_unit;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  logic        clk = 0;
  logic        rst_n = 1;
  logic        start = 0;
  logic        is_lr = 0;
  logic        is_sc = 0;
  logic        is_amo = 0;
  logic [4:0]  amo_funct5 = 0;
  logic [31:0] addr = 0;
  logic [31:0] rs2_data = 0;
  logic        flush = 0;
  logic        snoop_valid = 0;
  logic [31:0] snoop_addr = 0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        mem_ready = 0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        misaligned;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  int rd_stall = 0;
  int wr_stall = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic [31:0] w_addr = 0;
  logic [31:0] w_data = 0;
  logic        stable_bad = 0;
  logic        prev_stall = 0;
  logic        prev_we = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] prev_wdata = 0;

  int          lat;
  logic [31:0] res;
  logic        mis;
  logic        ill;
  int          drd;
  int          dwr;

  atomic_unit #(.ADDR_WIDTH(32), .GRANULE_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .is_lr(is_lr), .is_sc(is_sc), .is_amo(is_amo),
    .amo_funct5(amo_funct5), .addr(addr),
    .rs2_data(rs2_data), .flush(flush),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .result(result),
    .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Memory responder: stalls, counts and records accesses
  always @(negedge clk) begin
    if (prev_stall && mem_req && mem_we == prev_we &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata))
      stable_bad = 1'b1;
    if (mem_req && !busy)
      stable_bad = 1'b1;
    prev_stall = 1'b0;
    if (mem_req && !mem_we) begin
      if (rd_stall > 0) begin
        rd_stall--;
        mem_ready = 1'b0;
        prev_stall = 1'b1;
      end else begin
        mem_ready = 1'b1;
        n_rd++;
      end
    end else if (mem_req && mem_we) begin
      if (wr_stall > 0) begin
        wr_stall--;
        mem_ready = 1'b0;
        prev_stall = 1'b1;
      end else begin
        mem_ready = 1'b1;
        n_wr++;
        w_addr = mem_addr;
        w_data = mem_wdata;
      end
    end else begin
      mem_ready = 1'b0;
    end
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic lr, input logic sc,
                    input logic amo, input logic [4:0] f5,
                    input logic [31:0] a, input logic [31:0] rs2,
                    input logic [31:0] rdv, input int rs,
                    input int ws, input int snp_cyc,
                    input logic [31:0] snp_a);
    int b_rd;
    int b_wr;
    logic got;
    @(negedge clk);
    mem_rdata  = rdv;
    rd_stall   = rs;
    wr_stall   = ws;
    is_lr      = lr;
    is_sc      = sc;
    is_amo     = amo;
    amo_funct5 = f5;
    addr       = a;
    rs2_data   = rs2;
    start      = 1'b1;
    b_rd = n_rd;
    b_wr = n_wr;
    got  = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start       = 1'b0;
      snoop_valid = (i == snp_cyc);
      snoop_addr  = snp_a;
      if (done) begin
        lat = i;
        res = result;
        mis = misaligned;
        ill = illegal;
        got = 1'b1;
        break;
      end
    end
    snoop_valid = 1'b0;
    drd = n_rd - b_rd;
    dwr = n_wr - b_wr;
    chk("op_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic idle(input logic fl, input logic sv,
                      input logic [31:0] sa);
    @(negedge clk);
    flush       = fl;
    snoop_valid = sv;
    snoop_addr  = sa;
    @(negedge clk);
    flush       = 1'b0;
    snoop_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {26'd0, mem_req, mem_we, busy, done,
                    misaligned, illegal}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(1, 0, 0, F_ADD, 32'h100, 0, 32'hDEADBEEF, 0, 0, -1, 0);
    chk("lr_lat", 32'(lat), 32'd2);
    chk("lr_res", res, 32'hDEADBEEF);
    chk("lr_reads", 32'(drd), 32'd1);
    op(0, 1, 0, F_ADD, 32'h100, 5, 0, 0, 0, -1, 0);
    chk("sc_lat", 32'(lat), 32'd2);
    chk("sc_res", res, 32'd0);
    chk("sc_writes", 32'(dwr), 32'd1);
    chk("sc_waddr", w_addr, 32'h100);
    chk("sc_wdata", w_data, 32'd5);

    op(1, 0, 0, F_ADD, 32'h100, 0, 32'h1234, 0, 0, -1, 0);
    op(0, 1, 0, F_ADD, 32'h104, 9, 0, 0, 0, -1, 0);
    chk("scmiss_lat", 32'(lat), 32'd1);
    chk("scmiss_res", res, 32'd1);
    chk("scmiss_acc", 32'(drd + dwr), 32'd0);
    op(0, 1, 0, F_ADD, 32'h100, 9, 0, 0, 0, -1, 0);
    chk("sc2_res", res, 32'd1);
    chk("sc2_lat", 32'(lat), 32'd1);

    op(0, 0, 1, F_ADD, 32'h10, 2, 32'hFFFFFFFF, 0, 0, -1, 0);
    chk("add_lat", 32'(lat), 32'd3);
    chk("add_res", res, 32'hFFFFFFFF);
    chk("add_wdata", w_data, 32'h1);
    chk("add_waddr", w_addr, 32'h10);
    chk("add_acc", 32'(drd * 16 + dwr), 32'h11);
    op(0, 0, 1, F_MIN, 32'h10, 1, 32'h80000000, 0, 0, -1, 0);
    chk("min_wdata", w_data, 32'h80000000);
    op(0, 0, 1, F_MINU, 32'h10, 1, 32'h80000000, 0, 0, -1, 0);
    chk("minu_wdata", w_data, 32'h1);
    op(0, 0, 1, F_MAX, 32'h10, 1, 32'h80000000, 0, 0, -1, 0);
    chk("max_wdata", w_data, 32'h1);
    op(0, 0, 1, F_MAXU, 32'h10, 1, 32'h80000000, 0, 0, -1, 0);
    chk("maxu_wdata", w_data, 32'h80000000);
    op(0, 0, 1, F_XOR, 32'h14, 32'h0FF00F0F, 32'hF0F000FF,
       0, 0, -1, 0);
    chk("xor_wdata", w_data, 32'hFF000FF0);
    chk("xor_res", res, 32'hF0F000FF);
    op(0, 0, 1, F_AND, 32'h14, 32'h0FF00F0F, 32'hF0F000FF,
       0, 0, -1, 0);
    chk("and_wdata", w_data, 32'h00F0000F);
    op(0, 0, 1, F_OR, 32'h14, 32'h0FF00F0F, 32'hF0F000FF,
       0, 0, -1, 0);
    chk("or_wdata", w_data, 32'hFFF00FFF);

    op(1, 0, 0, F_ADD, 32'h200, 0, 32'h55, 0, 0, -1, 0);
    idle(0, 1, 32'h202);
    op(0, 1, 0, F_ADD, 32'h200, 7, 0, 0, 0, -1, 0);
    chk("snp_same_res", res, 32'd1);
    op(1, 0, 0, F_ADD, 32'h200, 0, 32'h55, 0, 0, -1, 0);
    idle(0, 1, 32'h204);
    op(0, 1, 0, F_ADD, 32'h200, 7, 0, 0, 0, -1, 0);
    chk("snp_other_res", res, 32'd0);
    chk("snp_other_wd", w_data, 32'd7);
    op(1, 0, 0, F_ADD, 32'h200, 0, 32'h55, 0, 0, 1, 32'h200);
    op(0, 1, 0, F_ADD, 32'h200, 7, 0, 0, 0, -1, 0);
    chk("snp_lrdone_res", res, 32'd1);
    op(1, 0, 0, F_ADD, 32'h200, 0, 32'h55, 0, 0, -1, 0);
    idle(1, 0, 0);
    op(0, 1, 0, F_ADD, 32'h200, 7, 0, 0, 0, -1, 0);
    chk("flush_res", res, 32'd1);

    stable_bad = 1'b0;
    op(0, 0, 1, F_SWAP, 32'h40, 32'h22, 32'h11, 3, 0, -1, 0);
    chk("swap_rst_lat", 32'(lat), 32'd6);
    chk("swap_rst_res", res, 32'h11);
    chk("swap_rst_wd", w_data, 32'h22);
    op(0, 0, 1, F_SWAP, 32'h40, 32'h33, 32'h22, 0, 3, -1, 0);
    chk("swap_wst_lat", 32'(lat), 32'd6);
    chk("swap_wst_res", res, 32'h22);
    chk("swap_wst_wd", w_data, 32'h33);
    chk("stall_stable", {31'd0, stable_bad}, 32'd0);

    op(1, 0, 0, F_ADD, 32'h102, 0, 32'h77, 0, 0, -1, 0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_flags", {30'd0, mis, ill}, 32'd2);
    chk("mis_res", res, 32'd0);
    chk("mis_acc", 32'(drd + dwr), 32'd0);
    op(1, 0, 0, F_ADD, 32'h300, 0, 32'hABCD, 0, 0, -1, 0);
    chk("lr300_res", res, 32'hABCD);
    op(0, 0, 1, 5'b00110, 32'h40, 1, 32'h9, 0, 0, -1, 0);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_flags", {30'd0, mis, ill}, 32'd1);
    chk("ill_res", res, 32'd0);
    chk("ill_acc", 32'(drd + dwr), 32'd0);

    @(negedge clk);
    mem_rdata  = 32'h1;
    rd_stall   = 0;
    wr_stall   = 10;
    is_lr      = 0;
    is_sc      = 0;
    is_amo     = 1;
    amo_funct5 = F_SWAP;
    addr       = 32'h300;
    rs2_data   = 32'h2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_wr", {30'd0, mem_req, mem_we}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {30'd0, mem_req, busy}, 32'd0);
    @(negedge clk);
    wr_stall = 0;
    rst_n    = 1'b1;
    op(0, 1, 0, F_ADD, 32'h300, 4, 0, 0, 0, -1, 0);
    chk("rst_sc_res", res, 32'd1);
    chk("rst_sc_lat", 32'(lat), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atomic_unit.md
Name: atomic_unit

Overview:
- Executes RV32A instructions (LR.W, SC.W, AMO*.W) after decode flags them as atomic; sits in the MEM stage between the pipeline and the data-memory port.
- Takes decoded is_lr/is_sc/is_amo/amo_funct5, effective address (rs1 + 0) and rs2 data.
- Sequences the read-modify-write, holds the LR reservation, and returns the rd value with a one-cycle done pulse. The pipeline stalls on busy.

Parameters:
- ADDR_WIDTH, 32, byte address width
- GRANULE_BITS, 2, low address bits ignored for reservation match (word granule)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  atomic op valid in MEM stage; sampled only in IDLE
- is_lr  input  1  decoded LR.W
- is_sc  input  1  decoded SC.W
- is_amo  input  1  decoded AMO*.W
- amo_funct5  input  5  instruction[31:27]
- addr  input  ADDR_WIDTH  effective address
- rs2_data  input  32  store/operand value
- flush  input  1  trap/mret/sret: clears reservation
- snoop_valid  input  1  another agent's store committed
- snoop_addr  input  ADDR_WIDTH  address of that store
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_WIDTH  word-aligned request address
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid with mem_ready on reads
- mem_ready  input  1  request completes this cycle
- busy  output  1  op in progress; pipeline stalls
- done  output  1  one-cycle pulse; result valid
- result  output  32  value for rd
- misaligned  output  1  with done: addr[1:0] != 0, no access made
- illegal  output  1  with done: unsupported amo_funct5, no access made

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, busy, done, misaligned, illegal = 0; result, mem_addr, mem_wdata = 0; reservation invalid.
- States: IDLE, READ, WRITE, DONE. busy=1 in READ and WRITE. done=1 only in DONE. mem_req=1 only in READ (we=0) and WRITE (we=1).
- IDLE + start:
  - Latch addr, rs2_data, op and funct5.
  - Misaligned or illegal funct5 -> DONE with the flag set and result=0.
  - LR or AMO -> READ.
  - SC with reservation hit -> WRITE.
  - SC with reservation miss -> DONE, result=1.
  - start with no op flag set is ignored.
  - start outside IDLE is ignored.
- Reservation hit = valid and stored addr[ADDR_WIDTH-1:GRANULE_BITS] equals addr[ADDR_WIDTH-1:GRANULE_BITS] and no same-cycle invalidating snoop/flush.
- READ: hold request until mem_ready, then capture old=mem_rdata.
  - LR: set reservation valid with the address, result=old, -> DONE.
  - AMO: compute new, -> WRITE.
- AMO ops (funct5):
  - 00001 SWAP: new=rs2
  - 00000 ADD: new=old+rs2, mod 2^32
  - 00100 XOR
  - 01100 AND
  - 01000 OR
  - 10000 MIN (signed)
  - 10100 MAX (signed)
  - 11000 MINU
  - 11100 MAXU
  - Any other AMO funct5 is illegal.
- WRITE: hold request with mem_wdata until mem_ready.
  - AMO: result=old.
  - SC: result=0, wdata=rs2.
  - -> DONE.
- DONE: one cycle, -> IDLE. Outputs other than done/flags hold until the next start.
- Reservation clear events:
  - Any SC, success or fail, at its start cycle.
  - flush.
  - snoop_valid with granule match.
- Reservation precedence:
  - Snoop/flush in the same cycle as LR completion: clear wins (reservation ends invalid).
  - A new LR overwrites any existing reservation.
- Latency with mem_ready=1 at first request cycle:
  - LR: done 2 cycles after start.
  - SC success: 2 cycles. SC fail: 1 cycle.
  - AMO: 3 cycles.
  - Each mem_ready stall cycle adds one.
- flush mid-operation does not abort an issued access; the op completes normally.
- Async reset mid-operation abandons the access immediately (mem_req=0).

Test Plan:
- LR.W addr=0x100, mem_rdata=0xDEADBEEF, ready immediate -> done at start+2, result=0xDEADBEEF; then SC.W 0x100 rs2=5 -> one write of 5 to 0x100, result=0, done at start+2.
- SC.W 0x104 after LR 0x100 -> no mem_req, done at start+1, result=1; a second SC.W 0x100 also fails (reservation cleared).
- AMOADD.W old=0xFFFFFFFF rs2=2 -> read then write 0x00000001, result=0xFFFFFFFF. AMOMIN old=0x80000000 rs2=1 -> write 0x80000000. AMOMINU same operands -> write 0x00000001.
- LR 0x200, then snoop_valid addr=0x202 -> SC 0x200 fails (result=1). Repeat with snoop=0x204 -> SC succeeds. Snoop on the LR completion cycle -> SC fails.
- mem_ready low 3 cycles in READ and in WRITE of AMOSWAP -> mem_req/mem_addr/mem_wdata stable, busy high, done at start+6.
- addr=0x102 -> misaligned=1, done at start+1, no mem_req. funct5=00110 -> illegal=1. rst_n low in WRITE -> mem_req=0 and reservation invalid asynchronously.
